// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Brief    : Pipelined ripple-carry add/subtract unit. Each stage ripples one
//            CHUNK-bit slice; valid/ready handshake with carry/ovf/zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_A,
    input  logic [WIDTH-1:0] io_in_B,
    input  logic             io_in_Cin,
    input  logic             io_in_sub,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_Sum,
    output logic             io_out_Cout,
    output logic             io_out_Ovf,
    output logic             io_out_Zero
);
    localparam int c_CHUNK = WIDTH / STAGES;
    localparam int c_LAST  = STAGES - 1;

    logic [STAGES-1:0] r_v_q, w_v_d;
    logic [STAGES-1:0] r_c_q, w_c_d;
    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  r_sum_q [STAGES];
    logic [WIDTH-1:0]  w_sum_d [STAGES];
    logic [WIDTH-1:0]  r_a_q   [STAGES];
    logic [WIDTH-1:0]  w_a_d   [STAGES];
    logic [WIDTH-1:0]  r_b_q   [STAGES];
    logic [WIDTH-1:0]  w_b_d   [STAGES];
    logic              r_ovf_q, w_ovf_d;
    logic              r_zero_q, w_zero_d;

    logic [STAGES-1:0] w_src_v, w_src_c;
    logic [WIDTH-1:0]  w_src_a   [STAGES];
    logic [WIDTH-1:0]  w_src_b   [STAGES];
    logic [WIDTH-1:0]  w_src_sum [STAGES];

    logic [WIDTH-1:0]  w_rsum;
    logic              w_carry;
    logic              w_cmsb;
    logic              w_unused;

    // Stage 0 takes the effective operands; later stages take the previous stage registers.
    always_comb begin : p_src
        w_src_v[0]   = io_in_valid;
        w_src_c[0]   = io_in_sub | io_in_Cin;
        w_src_a[0]   = io_in_A;
        w_src_b[0]   = io_in_sub ? ~io_in_B : io_in_B;
        w_src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k]   = r_v_q[k-1];
            w_src_c[k]   = r_c_q[k-1];
            w_src_a[k]   = r_a_q[k-1];
            w_src_b[k]   = r_b_q[k-1];
            w_src_sum[k] = r_sum_q[k-1];
        end
    end

    // Advance chain runs from the output back to the input so bubbles collapse.
    always_comb begin : p_ready
        w_adv         = '0;
        w_adv[c_LAST] = ~r_v_q[c_LAST] | io_out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = ~r_v_q[k] | w_adv[k+1];
        end
    end

    always_comb begin : p_stage
        w_v_d    = r_v_q;
        w_c_d    = r_c_q;
        w_ovf_d  = r_ovf_q;
        w_zero_d = r_zero_q;
        w_rsum   = '0;
        w_carry  = 1'b0;
        w_cmsb   = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_sum_d[k] = r_sum_q[k];
            w_a_d[k]   = r_a_q[k];
            w_b_d[k]   = r_b_q[k];
            w_rsum     = w_src_sum[k];
            w_carry    = w_src_c[k];
            w_cmsb     = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if ((i >= k * c_CHUNK) && (i < (k + 1) * c_CHUNK)) begin
                    if (i == WIDTH - 1) begin
                        w_cmsb = w_carry;
                    end
                    w_rsum[i] = w_src_a[k][i] ^ w_src_b[k][i] ^ w_carry;
                    w_carry   = (w_src_a[k][i] & w_src_b[k][i])
                              | (w_carry & (w_src_a[k][i] ^ w_src_b[k][i]));
                end
            end
            if (w_adv[k]) begin
                w_v_d[k] = w_src_v[k];
                if (w_src_v[k]) begin
                    w_sum_d[k] = w_rsum;
                    w_a_d[k]   = w_src_a[k];
                    w_b_d[k]   = w_src_b[k];
                    w_c_d[k]   = w_carry;
                    // Flags are only meaningful once the full-width sum exists.
                    if (k == c_LAST) begin
                        w_ovf_d  = w_cmsb ^ w_carry;
                        w_zero_d = (w_rsum == '0);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin : p_regs
        if (reset) begin
            r_v_q    <= '0;
            r_c_q    <= '0;
            r_ovf_q  <= 1'b0;
            r_zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum_q[k] <= '0;
                r_a_q[k]   <= '0;
                r_b_q[k]   <= '0;
            end
        end else begin
            r_v_q    <= w_v_d;
            r_c_q    <= w_c_d;
            r_ovf_q  <= w_ovf_d;
            r_zero_q <= w_zero_d;
            for (int k = 0; k < STAGES; k++) begin
                r_sum_q[k] <= w_sum_d[k];
                r_a_q[k]   <= w_a_d[k];
                r_b_q[k]   <= w_b_d[k];
            end
        end
    end

    // Last-stage operand copies have no consumer.
    assign w_unused     = ^{r_a_q[c_LAST], r_b_q[c_LAST]};

    assign io_in_ready  = w_adv[0];
    assign io_out_valid = r_v_q[c_LAST];
    assign io_out_Sum   = r_sum_q[c_LAST];
    assign io_out_Cout  = r_c_q[c_LAST];
    assign io_out_Ovf   = r_ovf_q;
    assign io_out_Zero  = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe
// Brief    : Directed 8-bit/2-stage checks plus randomized 32-bit regression
//            over STAGES = 1, 2, 4, 8 against a signed/unsigned arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   rand_go;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        longint      sa, sb, s;
        logic [32:0] full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            s      = sa - sb;
        end else begin
            full   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            e.sum  = full[31:0];
            e.cout = full[32];
            s      = sa + sb + (cin ? 64'sd1 : 64'sd0);
        end
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.zero = (e.sum == 32'd0);
        e.cyc  = 0;
        return e;
    endfunction

    // ---------------- directed instance: WIDTH=8, STAGES=2 ----------------
    logic       d_in_valid, d_in_ready, d_cin, d_sub;
    logic       d_out_valid, d_out_ready, d_cout, d_ovf, d_zero;
    logic [7:0] d_a, d_b, d_sum;

    adder_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clock(clk), .reset(rst),
        .io_in_valid(d_in_valid), .io_in_ready(d_in_ready),
        .io_in_A(d_a), .io_in_B(d_b), .io_in_Cin(d_cin), .io_in_sub(d_sub),
        .io_out_valid(d_out_valid), .io_out_ready(d_out_ready),
        .io_out_Sum(d_sum), .io_out_Cout(d_cout), .io_out_Ovf(d_ovf), .io_out_Zero(d_zero)
    );

    task automatic d_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic sub, input logic [10:0] exp);
        @(negedge clk);
        d_in_valid = 1'b1; d_a = a; d_b = b; d_cin = cin; d_sub = sub; d_out_ready = 1'b1;
        #1 check_value({tag, "_rdy"}, d_in_ready, 1);
        @(negedge clk);
        d_in_valid = 1'b0;
        check_value({tag, "_early"}, d_out_valid, 0);
        @(negedge clk);
        check_value({tag, "_vld"}, d_out_valid, 1);
        check_value(tag, {d_sum, d_cout, d_ovf, d_zero}, exp);
        @(negedge clk);
        check_value({tag, "_once"}, d_out_valid, 0);
    endtask

    // ---------------- random instances: WIDTH=32, STAGES=1,2,4,8 ----------------
    for (genvar j = 0; j < 4; j++) begin : g_rand
        localparam int c_ST = 1 << j;
        logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
        logic [31:0] a, b, sum;
        exp_t        q[$];
        bit          done;

        adder_pipe #(.WIDTH(32), .STAGES(c_ST)) u_dut (
            .clock(clk), .reset(rst),
            .io_in_valid(in_valid), .io_in_ready(in_ready),
            .io_in_A(a), .io_in_B(b), .io_in_Cin(cin), .io_in_sub(sub),
            .io_out_valid(out_valid), .io_out_ready(out_ready),
            .io_out_Sum(sum), .io_out_Cout(cout), .io_out_Ovf(ovf), .io_out_Zero(zero)
        );

        function automatic logic [31:0] pick();
            logic [31:0] corners [4];
            corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF;
            corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
            if ($urandom_range(0, 4) == 0) return corners[$urandom_range(0, 3)];
            return $urandom;
        endfunction

        initial begin
            int   last_low;
            exp_t e, f;
            string tag;
            tag = $sformatf("rnd_s%0d", c_ST);
            in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
            done = 1'b0;
            last_low = -1;
            wait (rand_go);
            for (int cyc = 0; cyc < 700; cyc++) begin
                @(negedge clk);
                if (cyc >= 600) begin
                    in_valid  = 1'b0;
                    out_ready = 1'b1;
                end else begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    a         = pick();
                    b         = pick();
                    cin       = 1'($urandom_range(0, 1));
                    sub       = 1'($urandom_range(0, 1));
                    out_ready = (cyc < 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                if (!out_ready) last_low = cyc;
                #1;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check_value({tag, "_unexp"}, 1, 0);
                    end else begin
                        f = q.pop_front();
                        check_value(tag, {sum, cout, ovf, zero}, {f.sum, f.cout, f.ovf, f.zero});
                        if (f.cyc > last_low) check_value({tag, "_lat"}, cyc - f.cyc, c_ST);
                    end
                end
                if (in_valid && in_ready) begin
                    e     = model(a, b, cin, sub);
                    e.cyc = cyc;
                    q.push_back(e);
                end
            end
            check_value({tag, "_drain"}, q.size(), 0);
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        n_checks = 0; n_fail = 0; rand_go = 1'b0;
        d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_out", {d_out_valid, d_sum, d_cout, d_ovf, d_zero}, 0);
        rst = 1'b0;
        #1 check_value("rst_rdy", d_in_ready, 1);

        d_single("wrap",   8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
        d_single("ovf_c1", 8'h7F, 8'h01, 1'b1, 1'b0, {8'h81, 1'b0, 1'b1, 1'b0});
        d_single("ovf_c0", 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0});
        d_single("sub_neg", 8'h05, 8'h07, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0, 1'b0});
        d_single("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1, 1'b0});

        // Backpressure: three beats offered with the consumer stalled.
        d_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_in_valid = 1'b1; d_a = 8'(16 * (i + 1)); d_b = 8'(i + 1); d_cin = 1'b0; d_sub = 1'b0;
            #1 check_value($sformatf("bp_rdy%0d", i), d_in_ready, (i < 2) ? 1 : 0);
        end
        check_value("bp_hold0", {d_out_valid, d_sum}, {1'b1, 8'h11});
        @(negedge clk);
        #1 check_value("bp_hold1", {d_out_valid, d_sum, d_in_ready}, {1'b1, 8'h11, 1'b0});
        @(negedge clk);
        d_out_ready = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(negedge clk);
                d_in_valid = 1'b0;
                #1;
            end
            if (d_out_valid && d_out_ready) begin
                check_value($sformatf("bp_out%0d", n), d_sum, 8'(8'h11 * (n + 1)));
                check_value($sformatf("bp_cyc%0d", n), c, n);
                n++;
            end
        end
        check_value("bp_count", n, 3);

        // Reset in the middle of a transfer, between clock edges.
        @(negedge clk);
        d_in_valid = 1'b1; d_a = 8'h12; d_b = 8'h34;
        @(negedge clk);
        d_a = 8'h56; d_b = 8'h01;
        @(negedge clk);
        d_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_value("mid_rst", {d_out_valid, d_sum}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_value("mid_rdy", d_in_ready, 1);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (d_out_valid) n++;
        end
        check_value("mid_stale", n, 0);

        rand_go = 1'b1;
        for (int t = 0; t < 5000; t++) begin
            if (g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done) break;
            @(negedge clk);
        end
        check_value("rnd_done",
                    {g_rand[0].done, g_rand[1].done, g_rand[2].done, g_rand[3].done}, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Parametrised, pipelined ripple-carry add/subtract unit that generalises the 8-bit full-adder chain for use in the ALU datapath. Operands are split into STAGES equal chunks. Each pipeline stage adds one chunk with a full-adder ripple chain and registers the carry into the next stage. Input and output use valid/ready handshakes, the pipeline holds its contents under backpressure, and the result carries carry, signed-overflow and zero flags.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 1.
STAGES, 4, number of pipeline stages, equal to the latency in cycles; must be >= 1 and divide WIDTH exactly. CHUNK = WIDTH/STAGES.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
io_in_valid  input  1  operand beat valid
io_in_ready  output  1  stage 0 can accept a beat
io_in_A  input  WIDTH  operand A
io_in_B  input  WIDTH  operand B
io_in_Cin  input  1  carry-in; used only when io_in_sub=0
io_in_sub  input  1  0 = A+B+Cin, 1 = A-B
io_out_valid  output  1  result beat valid
io_out_ready  input  1  consumer accepts the result
io_out_Sum  output  WIDTH  result
io_out_Cout  output  1  carry out of the MSB (for subtract: 1 = no borrow)
io_out_Ovf  output  1  two's-complement signed overflow
io_out_Zero  output  1  1 when io_out_Sum == 0

Behaviour:
- Effective operands:
  - Bop = io_in_sub ? ~io_in_B : io_in_B.
  - c0 = io_in_sub ? 1 : io_in_Cin.
- Stage k (k = 0..STAGES-1) holds a valid bit v[k] and the following registers:
  - the computed sum bits [CHUNK*(k+1)-1 : 0];
  - the still-unprocessed upper bits of A and Bop;
  - the carry out of chunk k;
  - the carry into the MSB, captured in the stage containing bit WIDTH-1.
- Stage k computes chunk k as a CHUNK-bit ripple from the carry registered in stage k-1. Stage 0 uses c0.
- Handshake:
  - Stage k advances when v[k]=0 or stage k+1 advances. The last stage advances when io_out_ready=1 or v[last]=0.
  - io_in_ready = stage 0 advances. This is combinational from io_out_ready through the chain; there is no combinational path from io_in_valid to io_in_ready.
  - A beat is accepted when io_in_valid && io_in_ready.
  - Bubbles collapse: an empty stage fills while downstream stages are stalled.
  - The result is emitted when io_out_valid && io_out_ready.
- Latency: exactly STAGES cycles from acceptance to io_out_valid when there is no backpressure. Throughput is 1 beat per cycle. Capacity is STAGES beats.
- Output registers:
  - io_out_valid = v[last].
  - Sum, Cout, Ovf and Zero come straight from last-stage registers. Zero is computed in the last stage from the full sum.
  - Ovf = carry into the MSB XOR carry out of the MSB.
- While io_out_valid=1 && io_out_ready=0, all output signals hold stable. A stalled stage's data is never overwritten.
- Result arithmetic is modulo 2^WIDTH; no saturation.
- Reset:
  - All v[k] clear immediately (asynchronously). Data registers clear to 0.
  - io_out_valid=0, io_out_Sum=0, io_out_Cout=0, io_out_Ovf=0, io_out_Zero=0.
  - io_in_ready is 1 as soon as reset deasserts.
- Reset mid-operation discards all in-flight beats; no partial result is emitted.
- STAGES=1: a single registered full-width ripple with latency 1.
- Simultaneous accept and emit while the pipeline is full is legal and sustains full throughput.

Test Plan:
(Run with WIDTH=8, STAGES=2 unless stated.)
- Carry wrap: A=0xFF, B=0x01, Cin=0, sub=0, out_ready=1 -> 2 cycles later Sum=0x00, Cout=1, Ovf=0, Zero=1, out_valid=1 for one cycle.
- Signed overflow: A=0x7F, B=0x01, Cin=1 -> Sum=0x81, Cout=0, Ovf=1, Zero=0. Also A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Ovf=1.
- Subtract: A=0x05, B=0x07, sub=1, Cin=1 (ignored) -> Sum=0xFE, Cout=0, Ovf=0. Also A=0x80, B=0x01, sub=1 -> Sum=0x7F, Cout=1, Ovf=1.
- Backpressure: out_ready=0, present 3 back-to-back beats (0x10+0x01, 0x20+0x02, 0x30+0x03).
  - in_ready drops after 2 beats are accepted; outputs hold at 0x11.
  - Raise out_ready -> 0x11, 0x22, 0x33 emitted in order on consecutive cycles, no loss or duplication.
- Reset mid-flight: accept 2 beats, assert reset asynchronously between edges -> out_valid=0 and Sum=0 immediately. After release, no stale result appears and in_ready=1.
- Random regression at WIDTH=32, STAGES in {1,2,4,8}: random A, B, Cin, sub and random out_ready toggling.
  - Compare every emitted beat against the 33-bit reference sum (Cout, Ovf, Zero) via an in-order scoreboard.
  - Check the latency equals STAGES whenever out_ready stays high.
